// File: rtl/varredura_7seg.sv
// varredura_7seg: time-multiplexed scan controller for N_DIGITOS common-anode
// digits sharing one 7-segment decoder. A shadow register (exibido) holds the
// value on display; new values wait in a pending register until the frame
// wraps, so a frame never mixes two values. BLANK dead time between digits
// prevents ghosting.
// Optional: define ZERO_SUPPRESS_EN for leading-zero suppression.
// Every output is a register, updated one cycle after the scan state that
// produced it; quadro_fim rises on the same edge that loads exibido.
module varredura_7seg #(
    parameter int N_DIGITOS    = 4,
    parameter int DIV_CICLOS   = 50000,
    parameter int BLANK_CICLOS = 16
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               carga,
    input  logic [4*N_DIGITOS-1:0]                             dado,
    output logic                                               pendente,
    output logic [3:0]                                         codigo,
    output logic [N_DIGITOS-1:0]                               anodo,
    output logic                                               apagar,
    output logic [((N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1)-1:0] digito,
    output logic                                               quadro_fim
);

    localparam int DW   = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam int MAXC = (DIV_CICLOS > BLANK_CICLOS) ? DIV_CICLOS : BLANK_CICLOS;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] ATIVO_ULT = CW'(DIV_CICLOS - 1);
    localparam logic [CW-1:0] BLANK_ULT = CW'((BLANK_CICLOS > 0) ? BLANK_CICLOS - 1 : 0);
    localparam logic [DW-1:0] DIG_ULT   = DW'(N_DIGITOS - 1);

    typedef enum logic {BLANK, ATIVO} estado_t;

    estado_t               estado, estado_prox;
    logic [DW-1:0]         idx, idx_prox;
    logic [CW-1:0]         cnt, cnt_prox;
    logic                  wrap;
    logic                  blank_fim, ativo_fim;
    logic                  suprimir;

    logic [4*N_DIGITOS-1:0] exibido;
    logic [4*N_DIGITOS-1:0] pend;

    logic [N_DIGITOS-1:0]  anodo_prox;
    logic                  apagar_prox;
    logic [3:0]            codigo_prox;

    assign blank_fim = (BLANK_CICLOS == 0) || (cnt == BLANK_ULT);
    assign ativo_fim = (cnt == ATIVO_ULT);

`ifdef ZERO_SUPPRESS_EN
    // digit idx>0 goes dark when it and every more significant nibble are zero
    assign suprimir = (idx != '0) && ((exibido >> {idx, 2'b00}) == '0);
`else
    assign suprimir = 1'b0;
`endif

    // scan state register
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= BLANK;
            idx    <= '0;
            cnt    <= '0;
        end else begin
            estado <= estado_prox;
            idx    <= idx_prox;
            cnt    <= cnt_prox;
        end
    end

    // next scan state: dwell counting, digit advance, frame wrap detection
    always_comb begin
        estado_prox = estado;
        idx_prox    = idx;
        cnt_prox    = cnt + 1'b1;
        wrap        = 1'b0;
        case (estado)
            BLANK: begin
                if (blank_fim) begin
                    estado_prox = ATIVO;
                    cnt_prox    = '0;
                end
            end
            ATIVO: begin
                if (ativo_fim) begin
                    cnt_prox    = '0;
                    estado_prox = (BLANK_CICLOS == 0) ? ATIVO : BLANK;
                    if (idx == DIG_ULT) begin
                        idx_prox = '0;
                        wrap     = 1'b1;
                    end else begin
                        idx_prox = idx + 1'b1;
                    end
                end
            end
            default: begin
                estado_prox = BLANK;
                cnt_prox    = '0;
            end
        endcase
    end

    // display outputs for the current scan state; codigo holds through BLANK
    always_comb begin
        anodo_prox  = '1;
        apagar_prox = 1'b1;
        codigo_prox = codigo;
        if (estado == ATIVO) begin
            codigo_prox = 4'(exibido >> {idx, 2'b00});
            if (!suprimir) begin
                anodo_prox  = ~(N_DIGITOS'(1) << idx);
                apagar_prox = 1'b0;
            end
        end
    end

    // pending/shadow value handling; exibido only moves at a frame wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            exibido    <= '0;
            pend       <= '0;
            pendente   <= 1'b0;
            quadro_fim <= 1'b0;
        end else begin
            quadro_fim <= wrap;
            if (wrap) begin
                pendente <= 1'b0;
                if (carga)
                    exibido <= dado;
                else if (pendente)
                    exibido <= pend;
            end else if (carga) begin
                pend     <= dado;
                pendente <= 1'b1;
            end
        end
    end

    // registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            anodo  <= '1;
            apagar <= 1'b1;
            codigo <= 4'h0;
            digito <= '0;
        end else begin
            anodo  <= anodo_prox;
            apagar <= apagar_prox;
            codigo <= codigo_prox;
            digito <= idx;
        end
    end

endmodule

// File: tb/tb_varredura_7seg.sv
// Bench for varredura_7seg: two instances (4 digits/DIV 4/BLANK 2 and
// 3 digits/DIV 3/BLANK 0) against a timeline model computed from elapsed
// cycles since reset, plus table and hand sequences for the corner cases.
module tb_varredura_7seg;

`ifdef ZERO_SUPPRESS_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, carga;
    logic [15:0] dado;
    logic [11:0] dado1;

    logic        pend0, ap0, qf0;
    logic [3:0]  cod0, an0;
    logic [1:0]  dg0;
    logic        pend1, ap1, qf1;
    logic [3:0]  cod1;
    logic [2:0]  an1;
    logic [1:0]  dg1;

    always #5 clk = ~clk;

    varredura_7seg #(.N_DIGITOS(4), .DIV_CICLOS(4), .BLANK_CICLOS(2)) dut (
        .clk(clk), .rst(rst), .carga(carga), .dado(dado), .pendente(pend0),
        .codigo(cod0), .anodo(an0), .apagar(ap0), .digito(dg0), .quadro_fim(qf0));

    varredura_7seg #(.N_DIGITOS(3), .DIV_CICLOS(3), .BLANK_CICLOS(0)) dut1 (
        .clk(clk), .rst(rst), .carga(carga), .dado(dado1), .pendente(pend1),
        .codigo(cod1), .anodo(an1), .apagar(ap1), .digito(dg1), .quadro_fim(qf1));

    int checks = 0;
    int errors = 0;

    int pn[2] = '{4, 3};
    int pd[2] = '{4, 3};
    int pb[2] = '{2, 0};

    // model state: cycles since reset edge, shown and pending values
    int          ms[2];
    logic [31:0] mex[2], mpd[2];
    bit          mpe[2];
    // expected outputs
    logic [3:0]  e_an[2], e_cod[2];
    bit          e_ap[2], e_qf[2], e_ck[2];
    int          e_dg[2];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h want %0h", nm, $time, a, e);
        end
    endtask

    // scan position after s edges since reset: lit?, digit index, and whether
    // edge s itself is the frame wrap
    function automatic void pos(input int n, input int d, input int b, input int s,
                                output bit at, output int dg, output bit wr);
        int first, p, u, k;
        first = (b > 0) ? b : 1;
        p = d + b;
        at = 0; dg = 0; wr = 0;
        if (s >= first) begin
            u  = s - first;
            k  = u / p;
            at = (u % p) < d;
            dg = at ? (k % n) : ((k + 1) % n);
            wr = (u >= 1) && ((u % (n * p)) == (((n - 1) * p + d) % (n * p)));
        end
    endfunction

    task automatic model(input int i, input bit r, input bit c, input logic [15:0] d);
        bit          at, wr, a2, wd;
        int          dg, dg2;
        logic [31:0] m, sh;
        logic [3:0]  ones;
        m    = (32'd1 << (4 * pn[i])) - 1;
        ones = 4'((1 << pn[i]) - 1);
        if (r) begin
            ms[i] = 0; mex[i] = 0; mpe[i] = 0;
            e_an[i] = ones; e_ap[i] = 1; e_qf[i] = 0; e_dg[i] = 0;
            e_cod[i] = 0; e_ck[i] = 1;
        end else begin
            pos(pn[i], pd[i], pb[i], ms[i], at, dg, wd);
            pos(pn[i], pd[i], pb[i], ms[i] + 1, a2, dg2, wr);
            ms[i]++;
            e_dg[i] = dg; e_qf[i] = wr; e_an[i] = ones; e_ap[i] = 1; e_ck[i] = at;
            if (at) begin
                sh = mex[i] >> (4 * dg);
                e_cod[i] = sh[3:0];
                if (!(ZS && dg > 0 && sh == 0)) begin
                    e_an[i] = ones & ~(4'(1) << dg);
                    e_ap[i] = 0;
                end
            end
            if (wr) begin
                if (c) mex[i] = {16'd0, d} & m;
                else if (mpe[i]) mex[i] = mpd[i];
                mpe[i] = 0;
            end else if (c) begin
                mpd[i] = {16'd0, d} & m;
                mpe[i] = 1;
            end
        end
    endtask

    task automatic compare();
        chk("anodo0",  32'(an0),  32'(e_an[0]));
        chk("apagar0", 32'(ap0),  32'(e_ap[0]));
        chk("qfim0",   32'(qf0),  32'(e_qf[0]));
        chk("digito0", 32'(dg0),  32'(e_dg[0]));
        chk("pend0",   32'(pend0), 32'(mpe[0]));
        if (e_ck[0]) chk("codigo0", 32'(cod0), 32'(e_cod[0]));
        chk("anodo1",  32'(an1),  32'(e_an[1]));
        chk("apagar1", 32'(ap1),  32'(e_ap[1]));
        chk("qfim1",   32'(qf1),  32'(e_qf[1]));
        chk("digito1", 32'(dg1),  32'(e_dg[1]));
        chk("pend1",   32'(pend1), 32'(mpe[1]));
        if (e_ck[1]) chk("codigo1", 32'(cod1), 32'(e_cod[1]));
    endtask

    task automatic tick(input bit r, input bit c, input logic [15:0] d);
        rst = r; carga = c; dado = d; dado1 = d[11:0];
        @(posedge clk);
        for (int i = 0; i < 2; i++) model(i, r, c, d);
        #1;
        compare();
    endtask

    typedef struct {
        logic [3:0] an;
        bit         ap;
        bit         ckcod;
        logic [3:0] cod;
    } vec_t;

    // reset, then release: table of the first cycles and first quadro_fim
    task automatic scen1(input int nrst);
        vec_t tab[9];
        int   n;
        for (int j = 0; j < 9; j++) tab[j] = '{4'hF, 1'b1, 1'b0, 4'h0};
        for (int j = 2; j < 6; j++) tab[j] = '{4'hE, 1'b0, 1'b1, 4'h0};
        tab[8] = ZS ? '{4'hF, 1'b1, 1'b1, 4'h0} : '{4'hD, 1'b0, 1'b1, 4'h0};
        for (int j = 0; j < nrst; j++) tick(1, 0, 16'h0);
        for (int j = 0; j < 9; j++) begin
            tick(0, 0, 16'h0);
            chk("tab_anodo",  32'(an0), 32'(tab[j].an));
            chk("tab_apagar", 32'(ap0), 32'(tab[j].ap));
            if (tab[j].ckcod) chk("tab_codigo", 32'(cod0), 32'(tab[j].cod));
        end
        n = 9;
        while (!qf0 && n < 60) begin tick(0, 0, 16'h0); n++; end
        chk("qfim_first_cycle", 32'(n), 32'd24);
    endtask

    // optionally wait for a wrap, then record {anodo,codigo} of each lit slot
    task automatic grab_frame(input bit wait_wrap, output logic [31:0] w, output int n);
        int b;
        bit pa;
        if (wait_wrap) begin
            b = 0;
            while (!qf0 && b < 100) begin tick(0, 0, 16'h0); b++; end
            chk("wrap_seen", 32'(qf0), 32'd1);
        end
        w = 0; n = 0; pa = 1;
        for (int k = 0; k < 24; k++) begin
            tick(0, 0, 16'h0);
            if (!ap0 && pa) begin w = (w << 8) | {24'd0, an0, cod0}; n++; end
            pa = ap0;
        end
    endtask

    function automatic bit next_wrap();
        bit at, wr; int dg;
        pos(4, 4, 2, ms[0] + 1, at, dg, wr);
        return wr;
    endfunction

    initial begin
        logic [31:0] w;
        int          n, b;
        bit          at, wd;
        int          dg;
        rst = 1; carga = 0; dado = 0; dado1 = 0;

        scen1(3);

        // load mid-frame: waits for the wrap, then 4,3,2,1
        for (int j = 0; j < 5; j++) tick(0, 0, 16'h0);
        tick(0, 1, 16'h1234);
        chk("pend_after_carga", 32'(pend0), 32'd1);
        grab_frame(1, w, n);
        chk("frame_1234", w, 32'hE4D3B271);
        chk("frame_1234_n", 32'(n), 32'd4);

        // latest carga wins
        tick(0, 1, 16'hAAAA);
        for (int j = 0; j < 3; j++) tick(0, 0, 16'h0);
        tick(0, 1, 16'h5555);
        grab_frame(1, w, n);
        chk("frame_5555", w, 32'hE5D5B575);
        chk("pend_after_wrap", 32'(pend0), 32'd0);

        // carga on the wrap edge goes straight to the display
        b = 0;
        while (!next_wrap() && b < 100) begin tick(0, 0, 16'h0); b++; end
        tick(0, 1, 16'h00F0);
        chk("wrapload_qfim", 32'(qf0), 32'd1);
        chk("wrapload_pend", 32'(pend0), 32'd0);
        grab_frame(0, w, n);
        chk("frame_00F0", w, ZS ? 32'h0000E0DF : 32'hE0DFB070);
        chk("frame_00F0_n", 32'(n), ZS ? 32'd2 : 32'd4);

        // reset in the middle of digit 2 with a value pending
        b = 0;
        pos(4, 4, 2, ms[0], at, dg, wd);
        while (!(at && dg == 2) && b < 100) begin
            tick(0, 0, 16'h0); b++;
            pos(4, 4, 2, ms[0], at, dg, wd);
        end
        tick(0, 1, 16'h9999);
        chk("pend_before_rst", 32'(pend0), 32'd1);
        tick(1, 0, 16'h0);
        chk("rst_anodo", 32'(an0), 32'hF);
        chk("rst_digito", 32'(dg0), 32'd0);
        chk("rst_pend", 32'(pend0), 32'd0);
        scen1(0);

        // leading zeros
        tick(0, 1, 16'h0050);
        grab_frame(1, w, n);
        chk("frame_0050", w, ZS ? 32'h0000E0D5 : 32'hE0D5B070);

        // random traffic, occasional reset
        for (int k = 0; k < 3000; k++)
            tick(($urandom % 400) == 0, ($urandom % 8) == 0, 16'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
